// File: rtl/rx_sequence_controller_if.sv
// ----------------------------------------------------------------------------
// rx_sequence_controller_if
// Purpose : bundles the detection/readout handshake between the peak finder,
//           the ARM-side reader and rx_sequence_controller.
// Signals :
//   idetect              one-clock peak-detected pulse from the peak finder
//   idetect_seq    [3:0] detected sequence index
//   idetect_value [40:0] signed peak value
//   iresult_acquired_arm ARM read acknowledge (level or pulse)
//   o_sample_arm  [40:0] latched peak value presented to the ARM
//   o_received_seq [3:0] latched sequence index
//   o_time_arm    [15:0] latched decimated-sample timestamp
//   o_trigger_arm        result-ready flag towards the ARM
//   ooverrun             sticky: a detection arrived while a result was pending
// Modports: master = peak finder / ARM side, slave = the controller.
// ----------------------------------------------------------------------------
interface rx_sequence_controller_if;
  logic               idetect;
  logic [3:0]         idetect_seq;
  logic signed [40:0] idetect_value;
  logic               iresult_acquired_arm;
  logic signed [40:0] o_sample_arm;
  logic [3:0]         o_received_seq;
  logic [15:0]        o_time_arm;
  logic               o_trigger_arm;
  logic               ooverrun;

  modport master (
    output idetect, idetect_seq, idetect_value, iresult_acquired_arm,
    input  o_sample_arm, o_received_seq, o_time_arm, o_trigger_arm, ooverrun
  );

  modport slave (
    input  idetect, idetect_seq, idetect_value, iresult_acquired_arm,
    output o_sample_arm, o_received_seq, o_time_arm, o_trigger_arm, ooverrun
  );
endinterface

// File: rtl/rx_sequence_controller.sv
// ----------------------------------------------------------------------------
// rx_sequence_controller
// Purpose : receive-chain sequencer. Generates the input-sample and
//           decimated-sample strobes plus a 16-bit decimated timestamp,
//           holds the datapath in reset while disabled, and hands detected
//           peaks to the ARM through a latch/trigger/acknowledge handshake
//           followed by a blanking window measured in decimated samples.
// Parameters:
//   SAMPLE_PERIOD  clocks between input samples
//   DECIM          input samples per decimated sample
//   BLANK_SAMPLES  decimated samples ignored after an acknowledged detection
// Ports:
//   crx_clk        clock
//   rrx_rst_n      asynchronous active-low reset
//   erx_en         enable; low clears timebase, handshake and overrun
//   bus            handshake interface (slave side)
//   osample_strobe input-sample pulse
//   odecim_strobe  decimated-sample pulse
//   ocurrent_time  decimated-sample timestamp (wraps silently)
//   odatapath_rst  active-high datapath reset
// ----------------------------------------------------------------------------
module rx_sequence_controller #(
  parameter int SAMPLE_PERIOD = 128,
  parameter int DECIM         = 4,
  parameter int BLANK_SAMPLES = 1024
) (
  input  logic                     crx_clk,
  input  logic                     rrx_rst_n,
  input  logic                     erx_en,
  rx_sequence_controller_if.slave  bus,
  output logic                     osample_strobe,
  output logic                     odecim_strobe,
  output logic [15:0]              ocurrent_time,
  output logic                     odatapath_rst
);

  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BL_W  = (BLANK_SAMPLES > 0) ? $clog2(BLANK_SAMPLES + 1) : 1;

  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DECIM - 1);
  localparam logic [BL_W-1:0]  BL_LOAD   = BL_W'(BLANK_SAMPLES);
  localparam logic [BL_W-1:0]  BL_ONE    = BL_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2,
    BLANK   = 2'd3
  } state_t;

  // Enable / datapath-reset sequencing
  logic               r_en_d1;
  logic               r_dp_rst;

  // Timebase
  logic [PER_W-1:0]   r_period_cnt;
  logic [PH_W-1:0]    r_phase_cnt;
  logic               r_decim_pend;
  logic [15:0]        r_time;

  // Handshake FSM
  state_t             r_state;
  logic [BL_W-1:0]    r_blank_cnt;
  logic signed [40:0] r_sample_arm;
  logic [3:0]         r_received_seq;
  logic [15:0]        r_time_arm;
  logic               r_trigger_arm;
  logic               r_overrun;

  logic               w_count_en;
  logic               w_sample_stb;
  logic               w_decim_stb;

  // Gating with erx_en keeps both strobes low in the very cycle the enable
  // drops, before the registered counters have been cleared.
  assign w_count_en   = erx_en & ~r_dp_rst;
  assign w_sample_stb = w_count_en & (r_period_cnt == PER_LAST);
  assign w_decim_stb  = w_count_en & r_decim_pend;

  // Datapath reset releases on the second clock that sees erx_en high; any
  // clock that sees erx_en low re-asserts it immediately.
  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_en_d1  <= 1'b0;
      r_dp_rst <= 1'b1;
    end else begin
      r_en_d1  <= erx_en;
      r_dp_rst <= ~(erx_en & r_en_d1);
    end
  end

  // Period counter -> sample strobe -> phase counter -> decim strobe (one
  // clock after the last sample of a group) -> timestamp.
  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_period_cnt <= '0;
      r_phase_cnt  <= '0;
      r_decim_pend <= 1'b0;
      r_time       <= '0;
    end else if (!w_count_en) begin
      r_period_cnt <= '0;
      r_phase_cnt  <= '0;
      r_decim_pend <= 1'b0;
      r_time       <= '0;
    end else begin
      r_period_cnt <= (r_period_cnt == PER_LAST) ? '0 : r_period_cnt + 1'b1;
      if (w_sample_stb) begin
        r_phase_cnt <= (r_phase_cnt == PH_LAST) ? '0 : r_phase_cnt + 1'b1;
      end
      r_decim_pend <= w_sample_stb & (r_phase_cnt == PH_LAST);
      if (w_decim_stb) begin
        r_time <= r_time + 16'd1;
      end
    end
  end

  // Detection handshake. The latch samples r_time before its increment on
  // the same edge, so a detect coinciding with a decim strobe reports the
  // pre-increment timestamp.
  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_state        <= IDLE;
      r_blank_cnt    <= '0;
      r_sample_arm   <= '0;
      r_received_seq <= '0;
      r_time_arm     <= '0;
      r_trigger_arm  <= 1'b0;
      r_overrun      <= 1'b0;
    end else if (!erx_en) begin
      r_state        <= IDLE;
      r_blank_cnt    <= '0;
      r_sample_arm   <= '0;
      r_received_seq <= '0;
      r_time_arm     <= '0;
      r_trigger_arm  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_dp_rst) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          // An acknowledge arriving here is meaningless and is dropped.
          if (bus.idetect) begin
            r_sample_arm   <= bus.idetect_value;
            r_received_seq <= bus.idetect_seq;
            r_time_arm     <= r_time;
            r_trigger_arm  <= 1'b1;
            r_state        <= PENDING;
          end
        end
        PENDING: begin
          if (bus.idetect) begin
            r_overrun <= 1'b1;
          end
          if (bus.iresult_acquired_arm) begin
            r_trigger_arm <= 1'b0;
            r_blank_cnt   <= BL_LOAD;
            r_state       <= (BLANK_SAMPLES == 0) ? RUN : BLANK;
          end
        end
        BLANK: begin
          if (w_decim_stb) begin
            r_blank_cnt <= r_blank_cnt - 1'b1;
            if (r_blank_cnt == BL_ONE) begin
              r_state <= RUN;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign osample_strobe     = w_sample_stb;
  assign odecim_strobe      = w_decim_stb;
  assign ocurrent_time      = r_time;
  assign odatapath_rst      = r_dp_rst;
  assign bus.o_sample_arm   = r_sample_arm;
  assign bus.o_received_seq = r_received_seq;
  assign bus.o_time_arm     = r_time_arm;
  assign bus.o_trigger_arm  = r_trigger_arm;
  assign bus.ooverrun       = r_overrun;

endmodule
